// File: rtl/spi_slave_trx_if.sv
// Word-stream bundle between the SPI slave and its host logic.
//
// Handshake: a word moves across a port on every rising clk edge where
// valid and ready are both 1. The sender keeps valid and data stable until
// that edge; the receiver may raise or drop ready at any time.
// tx_* flows host -> slave; rx_* flows slave -> host.
interface spi_slave_trx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_valid_o;
    logic                  rx_ready_i;

    modport slave (
        input  tx_data_i, tx_valid_i, rx_ready_i,
        output tx_ready_o, rx_data_o, rx_valid_o
    );

    modport master (
        output tx_data_i, tx_valid_i, rx_ready_i,
        input  tx_ready_o, rx_data_o, rx_valid_o
    );
endinterface

// File: rtl/spi_slave_trx.sv
// SPI slave transceiver: oversamples the external SPI pins with clk_i,
// supports all four CPOL/CPHA modes and MSB/LSB-first order, with a
// one-entry tx holding buffer and a one-word rx output register.
module spi_slave_trx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_i,
    input  logic              spi_sck_i,
    input  logic              spi_nss_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_en_o,
    spi_slave_trx_if.slave    stream,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              underrun_o,
    output logic              dbg_state_o
);
    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, nss_sync_q, mosi_sync_q;
    logic                   sck_d1_q, nss_d1_q;
    logic                   sck_s, nss_s, mosi_s;

    state_t state_q, state_d;

    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;

    logic sck_rise, sck_fall, lead_edge, trail_edge;
    logic in_frame, frame_start, frame_end;
    logic sample_edge, shift_edge, tx_load;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign nss_s  = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Synchronizers plus one delayed copy of SCK/NSS for edge detection;
    // reset values match an idle bus so release produces no false edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sck_sync_q  <= '0;
            nss_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_d1_q    <= 1'b0;
            nss_d1_q    <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_d1_q    <= sck_s;
            nss_d1_q    <= nss_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Frame next state: open on a select falling edge, close on select high or disable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (en_i && !nss_s && nss_d1_q) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!en_i || nss_s)             state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // SCK edges are only meaningful inside a frame that is not closing this cycle.
    always_comb begin
        sck_rise    = sck_s & ~sck_d1_q;
        sck_fall    = ~sck_s & sck_d1_q;
        lead_edge   = cpol_q ? sck_fall : sck_rise;
        trail_edge  = cpol_q ? sck_rise : sck_fall;
        in_frame    = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);
        frame_start = (state_q == ST_IDLE) && (state_d == ST_ACTIVE);
        frame_end   = (state_q == ST_ACTIVE) && (state_d == ST_IDLE);
        sample_edge = in_frame & (cpha_q ? trail_edge : lead_edge);
        shift_edge  = in_frame & (cpha_q ? lead_edge : trail_edge);
        // A shift edge seen with the counter at zero starts a new word in
        // both phases: for cpha=0 it follows the last sample of a word, for
        // cpha=1 it is the first leading edge of a word.
        tx_load     = (frame_start & ~cpha_i) | (shift_edge & (bit_cnt_q == '0));
    end

    // Datapath next state: tx buffer/shifter, rx shifter, rx output register.
    always_comb begin
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        underrun_d = 1'b0;

        if (frame_start) begin
            cpol_d = cpol_i;
            cpha_d = cpha_i;
            lsb_d  = lsb_i;
        end

        if (tx_load) begin
            tx_sr_d    = tx_full_q ? tx_buf_q : '0;
            tx_full_d  = 1'b0;
            underrun_d = ~tx_full_q;
        end else if (shift_edge) begin
            tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
        end

        // Accept only into an empty buffer, so it never collides with a load.
        if (stream.tx_valid_i && !tx_full_q) begin
            tx_buf_d  = stream.tx_data_i;
            tx_full_d = 1'b1;
        end

        if (rx_valid_q && stream.rx_ready_i) rx_valid_d = 1'b0;

        if (sample_edge) begin
            rx_sr_d = lsb_q ? {mosi_s, rx_sr_q[DATA_WIDTH-1:1]}
                            : {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                if (rx_valid_q && !stream.rx_ready_i) begin
                    overrun_d = 1'b1;
                end else begin
                    rx_data_d  = rx_sr_d;
                    rx_valid_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // A frame closing mid-word throws the partial word away.
        if (frame_end) begin
            bit_cnt_d = '0;
            rx_sr_d   = '0;
        end

        if (!en_i) begin
            tx_full_d  = 1'b0;
            rx_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign spi_miso_o        = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_WIDTH-1];
    assign spi_miso_en_o     = (state_q == ST_ACTIVE);
    assign busy_o            = (state_q == ST_ACTIVE);
    assign dbg_state_o       = state_q;
    assign stream.tx_ready_o = ~tx_full_q;
    assign stream.rx_data_o  = rx_data_q;
    assign stream.rx_valid_o = rx_valid_q;
    assign overrun_o         = overrun_q;
    assign underrun_o        = underrun_q;
endmodule

// File: tb/tb_spi_slave_trx.sv
// Bench for spi_slave_trx: drives an SPI master in all modes and checks
// MISO words, rx words, overrun/underrun pulses and reset behaviour against
// a word-level model of the tx buffer and rx output register.
module tb_spi_slave_trx;
  localparam int DW = 8;
  localparam int T  = 8;  // SCK half period in clk cycles

  logic clk, rst_n, en;
  logic cpol, cpha, lsb;
  logic spi_sck, spi_nss, spi_mosi;
  logic spi_miso, spi_miso_en;
  logic busy, overrun, underrun, dbg_state;

  spi_slave_trx_if #(.DATA_WIDTH(DW)) sif ();

  spi_slave_trx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb),
    .spi_sck_i(spi_sck), .spi_nss_i(spi_nss), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso), .spi_miso_en_o(spi_miso_en),
    .stream(sif),
    .busy_o(busy), .overrun_o(overrun), .underrun_o(underrun),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];       // rx words expected at the handshake
  logic [DW-1:0] model_buf[$];   // tx holding buffer contents
  logic [DW-1:0] exp_miso;       // word the current tx load should send
  logic [DW-1:0] mo_words[2];
  logic          rx_held;
  int            exp_und, exp_ovr;
  int            und_seen = 0, ovr_seen = 0, vld_cycles = 0;
  int            cur_cpol, cur_cpha, cur_lsb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters and rx handshake checker.
  always @(negedge clk) begin
    if (rst_n) begin
      if (underrun) und_seen++;
      if (overrun) ovr_seen++;
      if (sif.rx_valid_o) vld_cycles++;
      if (sif.rx_valid_o && sif.rx_ready_i) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected", {31'b0, sif.rx_valid_o}, 32'd0);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("rx_data", sif.rx_data_o, e);
        end
      end
    end
  end

  // ---------------- model ----------------
  task automatic model_load();
    if (model_buf.size() > 0) exp_miso = model_buf.pop_front();
    else begin
      exp_miso = '0;
      exp_und++;
    end
  endtask

  task automatic model_rx_word(input logic [DW-1:0] w);
    if (rx_held && !sif.rx_ready_i) exp_ovr++;
    else begin
      exp_q.push_back(w);
      rx_held = !sif.rx_ready_i;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input int p, input int h, input int l);
    cur_cpol = p; cur_cpha = h; cur_lsb = l;
    cpol = p[0]; cpha = h[0]; lsb = l[0];
    spi_sck = p[0];
    wait_cyc(T);
  endtask

  task automatic push_tx(input logic [DW-1:0] w);
    int waited = 0;
    while (!sif.tx_ready_o && waited < 100) begin
      wait_cyc(1);
      waited++;
    end
    check("tx_ready_timeout", {31'b0, sif.tx_ready_o}, 32'd1);
    sif.tx_data_i  = w;
    sif.tx_valid_i = 1'b1;
    wait_cyc(1);
    sif.tx_valid_i = 1'b0;
    model_buf.push_back(w);
  endtask

  task automatic xfer_bits(input int n, input logic [DW-1:0] mo, output logic [DW-1:0] mi);
    int idx;
    mi = '0;
    for (int i = 0; i < n; i++) begin
      idx = (cur_lsb != 0) ? i : DW - 1 - i;
      if (cur_cpha == 0) begin
        spi_mosi = mo[idx];
        wait_cyc(T);
        mi[idx] = spi_miso;
        spi_sck = ~cur_cpol[0];
        wait_cyc(T);
        spi_sck = cur_cpol[0];
      end else begin
        spi_sck = ~cur_cpol[0];
        spi_mosi = mo[idx];
        wait_cyc(T);
        mi[idx] = spi_miso;
        spi_sck = cur_cpol[0];
        wait_cyc(T);
      end
    end
  endtask

  // One frame of nw words; the last word carries last_bits bits.
  task automatic run_frame(input int nw, input int last_bits);
    int u0, o0, nb;
    logic [DW-1:0] mi;
    u0 = und_seen; o0 = ovr_seen;
    exp_und = 0; exp_ovr = 0;
    spi_nss = 1'b0;
    wait_cyc(T);
    check("busy_in_frame", {30'b0, busy, spi_miso_en}, 32'd3);
    if (cur_cpha == 0) model_load();
    for (int k = 0; k < nw; k++) begin
      nb = (k == nw - 1) ? last_bits : DW;
      if (cur_cpha != 0) model_load();
      if (nb == DW) model_rx_word(mo_words[k]);
      xfer_bits(nb, mo_words[k], mi);
      if (nb == DW) check("miso_word", mi, exp_miso);
      if (nb == DW && cur_cpha == 0) model_load();
    end
    wait_cyc(T);
    spi_nss = 1'b1;
    wait_cyc(2 * T);
    check("busy_after_frame", {31'b0, busy}, 32'd0);
    check("underrun_count", 32'(und_seen - u0), 32'(exp_und));
    check("overrun_count", 32'(ovr_seen - o0), 32'(exp_ovr));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0, nw;
    rst_n = 1'b0; en = 1'b1;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    cur_cpol = 0; cur_cpha = 0; cur_lsb = 0;
    spi_sck = 1'b0; spi_nss = 1'b1; spi_mosi = 1'b0;
    sif.tx_data_i = '0; sif.tx_valid_i = 1'b0; sif.rx_ready_i = 1'b1;
    rx_held = 1'b0; exp_miso = '0; exp_und = 0; exp_ovr = 0;
    wait_cyc(3);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_miso_en", {31'b0, spi_miso_en}, 32'd0);
    check("rst_miso", {31'b0, spi_miso}, 32'd0);
    check("rst_rx_valid", {31'b0, sif.rx_valid_o}, 32'd0);
    check("rst_rx_data", sif.rx_data_o, 32'd0);
    check("rst_pulses", {30'b0, overrun, underrun}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(1);
    check("rst_tx_ready", {31'b0, sif.tx_ready_o}, 32'd1);
    wait_cyc(T);

    // Mode 0 MSB-first: tx 0xA5, master sends 0x3C.
    set_mode(0, 0, 0);
    push_tx(8'hA5);
    mo_words[0] = 8'h3C;
    v0 = vld_cycles;
    run_frame(1, 8);
    check("mode0_valid_cycles", 32'(vld_cycles - v0), 32'd1);

    // Mode 3 LSB-first: tx 0x81, master sends 0x0F.
    set_mode(1, 1, 1);
    push_tx(8'h81);
    mo_words[0] = 8'h0F;
    run_frame(1, 8);

    // Frame with an empty tx buffer.
    set_mode(0, 1, 0);
    mo_words[0] = 8'($urandom);
    run_frame(1, 8);

    // Two words with the receiver stalled.
    set_mode(0, 0, 0);
    push_tx(8'($urandom));
    sif.rx_ready_i = 1'b0;
    mo_words[0] = 8'($urandom);
    mo_words[1] = 8'($urandom);
    run_frame(2, 8);
    check("stall_rx_valid", {31'b0, sif.rx_valid_o}, 32'd1);
    check("stall_rx_held", sif.rx_data_o, mo_words[0]);
    sif.rx_ready_i = 1'b1;
    rx_held = 1'b0;
    wait_cyc(4);
    check("stall_rx_drained", {31'b0, sif.rx_valid_o}, 32'd0);

    // Select raised after 5 bits, then a full 0x55 frame.
    set_mode(0, 0, 0);
    push_tx(8'($urandom));
    mo_words[0] = 8'($urandom);
    v0 = vld_cycles;
    run_frame(1, 5);
    check("partial_no_valid", 32'(vld_cycles - v0), 32'd0);
    push_tx(8'($urandom));
    mo_words[0] = 8'h55;
    run_frame(1, 8);

    // Disable flushes the tx buffer.
    push_tx(8'($urandom));
    en = 1'b0;
    wait_cyc(2);
    check("disable_flush", {30'b0, sif.tx_ready_o, busy}, 32'd2);
    en = 1'b1;
    model_buf.delete();
    wait_cyc(2);

    // Reset in the middle of a frame.
    set_mode(0, 0, 0);
    push_tx(8'($urandom));
    spi_nss = 1'b0;
    wait_cyc(T);
    begin
      logic [DW-1:0] junk;
      xfer_bits(3, 8'($urandom), junk);
    end
    rst_n = 1'b0;
    wait_cyc(1);
    check("midrst_busy_en", {30'b0, busy, spi_miso_en}, 32'd0);
    check("midrst_state", {31'b0, dbg_state}, 32'd0);
    check("midrst_miso", {31'b0, spi_miso}, 32'd0);
    check("midrst_rx", {23'b0, sif.rx_valid_o, sif.rx_data_o}, 32'd0);
    check("midrst_pulses", {30'b0, overrun, underrun}, 32'd0);
    spi_nss = 1'b1;
    spi_sck = cur_cpol[0];
    wait_cyc(2);
    rst_n = 1'b1;
    model_buf.delete();
    rx_held = 1'b0;
    wait_cyc(1);
    check("midrst_tx_ready", {31'b0, sif.tx_ready_o}, 32'd1);
    wait_cyc(T);
    push_tx(8'($urandom));
    mo_words[0] = 8'($urandom);
    run_frame(1, 8);

    // Randomized frames across all modes.
    for (int f = 0; f < 24; f++) begin
      set_mode($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) push_tx(8'($urandom));
      nw = $urandom_range(1, 2);
      mo_words[0] = 8'($urandom);
      mo_words[1] = 8'($urandom);
      run_frame(nw, 8);
    end

    // ---------------- final report ----------------
    wait_cyc(20);
    check("rx_words_left", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_trx.md
SPI_SLAVE_TRX -- requirements
Module: spi_slave_trx

Interface
REQ-001 Parameter DATA_WIDTH, 8, SHALL set the frame word width in bits (legal range 4..32).
REQ-002 Parameter SYNC_STAGES, 2, SHALL set the synchronizer depth on spi_sck_i, spi_nss_i and spi_mosi_i (legal range 2..3).
REQ-003 clk_i  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 rst_n_i  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 en_i  input  1  SHALL be the block enable.
REQ-006 cpol_i, cpha_i, lsb_i  input  1 each  SHALL select SPI clock polarity, clock phase and LSB-first order.
REQ-007 spi_sck_i, spi_nss_i, spi_mosi_i  input  1 each  SHALL be the asynchronous external SPI clock, active-low select and master-out data.
REQ-008 spi_miso_o  output  1  SHALL be the slave-out data; spi_miso_en_o  output  1  SHALL be its tri-state enable.
REQ-009 tx_data_i  input  DATA_WIDTH, tx_valid_i  input  1, tx_ready_o  output  1  SHALL form the transmit valid/ready port.
REQ-010 rx_data_o  output  DATA_WIDTH, rx_valid_o  output  1, rx_ready_i  input  1  SHALL form the receive valid/ready port.
REQ-011 busy_o, overrun_o, underrun_o  output  1 each  SHALL indicate an active frame, a dropped rx word (1-cycle pulse) and a tx load with an empty buffer (1-cycle pulse).

Function
REQ-012 External inputs SHALL pass through SYNC_STAGES flops; SCK edges SHALL be detected by comparing the synchronized SCK with its one-cycle-delayed copy (internal edge pulse SYNC_STAGES+1 cycles after the pin toggles).
REQ-013 Legal operation SHALL require each SCK phase to last >= 4 clk_i cycles; NSS setup before the first SCK edge >= 4 clk_i cycles.
REQ-014 Leading edge SHALL be the SCK transition away from cpol; trailing edge the transition back to cpol.
REQ-015 Sample edge SHALL be the leading edge when cpha=0 and the trailing edge when cpha=1; the shift edge SHALL be the other one.
REQ-016 FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synchronized NSS falling with en_i=1; ACTIVE->IDLE on synchronized NSS rising or en_i=0.
REQ-017 cpol_i, cpha_i and lsb_i SHALL be captured on IDLE->ACTIVE and held constant for the whole frame.
REQ-018 busy_o and spi_miso_en_o SHALL be 1 exactly while in ACTIVE.
REQ-019 Tx holding buffer SHALL be one entry; tx_ready_o = buffer empty; a word SHALL be accepted when tx_valid_i & tx_ready_o.
REQ-020 A tx load SHALL move the buffer into the tx shift register and empty the buffer; if the buffer is empty, the shift register SHALL load all zeros and underrun_o SHALL pulse.
REQ-021 cpha=0: a tx load SHALL occur on IDLE->ACTIVE and on each shift edge that follows the last sample edge of a word; other shift edges SHALL shift the register by one bit.
REQ-022 cpha=1: a tx load SHALL occur on the first leading edge of each word; other shift edges SHALL shift the register by one bit.
REQ-023 spi_miso_o SHALL be the tx shift register's MSB (lsb=0) or LSB (lsb=1).
REQ-024 Each sample edge SHALL shift spi_mosi_i into the rx shift register in the selected order and increment a bit counter that wraps from DATA_WIDTH-1 to 0.
REQ-025 On the sample edge of bit DATA_WIDTH-1, the assembled word SHALL appear on rx_data_o with rx_valid_o=1 on the following cycle, unless rx_valid_o is already 1 and rx_ready_i is 0 in that cycle; then the new word SHALL be dropped, rx_data_o SHALL be held and overrun_o SHALL pulse.
REQ-026 rx_valid_o SHALL clear the cycle after rx_valid_o & rx_ready_i, unless a new word completes in that same cycle, in which case the new word SHALL be presented with rx_valid_o held at 1.
REQ-027 NSS deassertion mid-word SHALL discard the partial rx word and reset the bit counter; the tx holding buffer SHALL be preserved.
REQ-028 en_i=0 SHALL force IDLE, flush the tx buffer, clear rx_valid_o and ignore SCK/NSS activity.

Reset
REQ-029 While rst_n_i=0 at a clk_i edge: FSM=IDLE; shift registers, bit counter, rx_data_o=0; spi_miso_o, spi_miso_en_o, busy_o, rx_valid_o, overrun_o, underrun_o = 0; tx buffer empty (tx_ready_o=1 from the first cycle after reset release).
REQ-030 Synchronizer flops SHALL reset to NSS=1, SCK=0, MOSI=0 so that no false edge is detected on reset release.

Verification
REQ-031 Mode 0, DATA_WIDTH=8, tx buffer=0xA5, master sends 0x3C MSB-first -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C with a one-cycle rx_valid_o pulse when rx_ready_i=1.
REQ-032 Mode 3, lsb_i=1, tx=0x81, master sends 0x0F -> MISO LSB-first 1,0,0,0,0,0,0,1; rx_data_o=0x0F.
REQ-033 Two back-to-back words with rx_ready_i=0 -> first word held on rx_data_o, overrun_o pulses once, second word lost.
REQ-034 Frame started with the tx buffer empty -> underrun_o pulses once, MISO all zeros for that word.
REQ-035 NSS raised after 5 bits, then a new frame of 0x55 -> no rx_valid_o for the partial word, next rx_data_o=0x55.
REQ-036 Synchronous reset asserted mid-frame -> all outputs at reset values on the next cycle; a subsequent frame completes correctly.
